// File: rtl/decode_router.sv
// Routes one-hot decoded requests onto per-slave strobes, locking the grant while
// transactions are outstanding and returning the granted slave's responses.
//   state | meaning
//   IDLE  | nothing outstanding, no grant held
//   BUSY  | count>0 transactions outstanding on slave 'grant'
//   ERR   | request decoded to no slave; bus error being returned this cycle
module decode_router #(
  parameter int NS         = 2,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LGMAXBURST = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_cyc,
  input  logic             i_valid,
  output logic             o_stall,
  input  logic [NS:0]      i_decode,
  input  logic [AW-1:0]    i_addr,
  input  logic [DW-1:0]    i_data,
  output logic [NS-1:0]    o_s_stb,
  output logic [AW-1:0]    o_s_addr,
  output logic [DW-1:0]    o_s_data,
  input  logic [NS-1:0]    i_s_stall,
  input  logic [NS-1:0]    i_s_ack,
  input  logic [NS-1:0]    i_s_err,
  input  logic [NS*DW-1:0] i_s_rdata,
  output logic             o_ack,
  output logic             o_err,
  output logic [DW-1:0]    o_rdata
);

  localparam int GW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [LGMAXBURST-1:0] MAX_CNT = '1;

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t                state, state_n;
  logic [LGMAXBURST-1:0] count, count_n;
  logic [GW-1:0]         grant, grant_n, sel;
  logic                  g_ack, g_err, resp;
  logic [DW-1:0]         g_rdata;
  logic                  stall_c;
  logic                  accept, accept_slave, accept_none;

  // Granted-slave response mux and one-hot to index encode of the request.
  always_comb begin
    g_ack   = 1'b0;
    g_err   = 1'b0;
    g_rdata = '0;
    sel     = '0;
    for (int k = 0; k < NS; k++) begin
      if (grant == GW'(k)) begin
        g_ack   = i_s_ack[k];
        g_err   = i_s_err[k];
        g_rdata = i_s_rdata[k*DW +: DW];
      end
      if (i_decode[k]) sel = GW'(k);
    end
  end

  assign resp         = (count != '0) && (g_ack || g_err);
  assign accept       = i_cyc && i_valid && !o_stall;
  assign accept_slave = accept && (|i_decode[NS-1:0]);
  assign accept_none  = accept && i_decode[NS];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      count   <= '0;
      grant   <= '0;
      o_ack   <= 1'b0;
      o_err   <= 1'b0;
      o_rdata <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      grant <= grant_n;
      if (!i_cyc) begin
        o_ack <= 1'b0;
        o_err <= 1'b0;
      end else begin
        o_ack <= (count != '0) && g_ack;
        o_err <= accept_none || ((count != '0) && g_err);
        if ((count != '0) && g_ack) o_rdata <= g_rdata;
      end
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    grant_n = grant;
    if (!i_cyc) begin
      state_n = IDLE;
      count_n = '0;
      grant_n = '0;
    end else begin
      if (accept_slave) grant_n = sel;
      // Simultaneous accept and response cancel out.
      if (accept_slave && !resp)      count_n = count + 1'b1;
      else if (resp && !accept_slave) count_n = count - 1'b1;
      if (accept_none)            state_n = ERR;
      else if (count_n != '0)     state_n = BUSY;
      else                        state_n = IDLE;
    end
  end

  always_comb begin
    stall_c = !i_cyc || (state == ERR) || (i_decode[NS] && (count != '0));
    o_s_stb = '0;
    for (int k = 0; k < NS; k++) begin
      if (i_decode[k] && (((count != '0) && (grant != GW'(k)))
                          || (count == MAX_CNT) || i_s_stall[k]))
        stall_c = 1'b1;
      o_s_stb[k] = i_cyc && i_valid && i_decode[k] && (state != ERR)
                   && ((count == '0) || (grant == GW'(k))) && (count != MAX_CNT);
    end
    o_stall = i_valid && stall_c;
  end

  assign o_s_addr = i_addr;
  assign o_s_data = i_data;

endmodule
